dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: DEPTH, 1024, number of 32-bit words in the attached data memory; valid word addresses are 0..DEPTH-1.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-004 req0, req1  input  1 each  access request from port 0 (core load/store) and port 1 (loader/DMA).
REQ-005 we0, we1  input  1 each  1 = write, 0 = read; qualified by reqN.
REQ-006 a0, a1  input  32 each  word address.
REQ-007 wd0, wd1  input  32 each  write data.
REQ-008 gnt0, gnt1  output  1 each  request accepted this cycle.
REQ-009 done0, done1  output  1 each  one-cycle completion pulse for that port.
REQ-010 rdata  output  32  read data; valid only while a done pulse is high.
REQ-011 err  output  1  out-of-range access; valid only while a done pulse is high.
REQ-012 mem_we  output  1  memory write enable.
REQ-013 mem_a, mem_wd  output  32 each  memory address and write data.
REQ-014 mem_rd  input  32  memory read data; combinational function of mem_a within the same cycle.

Function
REQ-015 FSM states: IDLE, ACCESS, RESP; IDLE->ACCESS on acceptance, ACCESS->RESP unconditionally, RESP->IDLE unconditionally; one access per 3 cycles.
REQ-016 Acceptance only in IDLE; gnt is combinational: gntN=1 iff state=IDLE, reqN=1, and N wins arbitration; at most one gnt high; gnt=0 in ACCESS, RESP and during reset.
REQ-017 Arbitration: single requester wins; if both request, the port not served by the last accepted access wins; rr flag resets to "port 1 last", so port 0 wins the first tie.
REQ-018 Requester holds reqN, weN, aN, wdN stable until it samples gntN=1 on a rising edge; that request is then consumed; a new access needs req still or again high after done.
REQ-019 On acceptance, register winner id, we, address into mem_a, write data into mem_wd, in-range flag (address < DEPTH), and update rr.
REQ-020 mem_a and mem_wd hold their registered values outside ACCESS.
REQ-021 ACCESS: mem_we=1 iff latched we=1 and in range; the write occurs on the edge ending ACCESS; mem_we=0 in all other states.
REQ-022 ACCESS: on the ending edge, rdata register loads mem_rd for an in-range read, 32'd0 for an out-of-range read or any write; err register loads NOT in-range.
REQ-023 RESP: doneN=1 for the latched winner only, for exactly one cycle; rdata/err hold until the next access's ACCESS edge.
REQ-024 Out-of-range access completes normally (gnt, done), never asserts mem_we, returns rdata=0, err=1.
REQ-025 Requests arriving during ACCESS/RESP wait; no request is dropped or reordered within a port.
REQ-026 Latency: gnt in cycle T, memory write on the edge ending T+1, done in cycle T+2.

Reset
REQ-027 While rst=0: state=IDLE, rr="port 1 last", gnt0=gnt1=0, done0=done1=0, mem_we=0, mem_a=0, mem_wd=0, rdata=0, err=0.
REQ-028 Reset asserted during ACCESS aborts the access asynchronously: mem_we falls immediately, no memory write occurs, no done is issued; after release, a still-asserted request is re-arbitrated from IDLE.

Verification
REQ-029 Preload mem[28]=0x00000020; port 0 read a0=28 -> gnt0 cycle T, done0 cycle T+2, rdata=0x00000020, err=0.
REQ-030 req0 and req1 both high from reset release, held -> grants alternate 0,1,0,1 at cycles T, T+3, T+6, T+9.
REQ-031 Port 1 writes a1=40, wd1=0xDEADBEEF, then port 0 reads a0=40 -> mem_we high one cycle with mem_a=40; read returns rdata=0xDEADBEEF.
REQ-032 Port 0 writes a0=1024 (DEPTH) -> mem_we never high, done0 pulses, err=1, rdata=0.
REQ-033 rst driven low mid-ACCESS of a write to address 40 -> mem_we low immediately, mem[40] unchanged, no done; outputs match REQ-027.
REQ-034 req1 alone asserted for 3 accesses with different addresses -> each gnt1 is exactly 3 cycles apart, done1 follows each gnt1 by 2 cycles, gnt0 never high.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory.
// One access every three cycles (IDLE -> ACCESS -> RESP); ties alternate between ports.
module dmem_arbiter #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] a0,
    input  logic [31:0] a1,
    input  logic [31:0] wd0,
    input  logic [31:0] wd1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        last1;
    logic        win_q;
    logic        we_q;
    logic        in_range_q;
    logic        pick1;
    logic        accept;
    logic        sel_we;
    logic [31:0] sel_a;
    logic [31:0] sel_wd;

    // Port 1 wins when alone, or on a tie when port 0 was served last.
    always_comb begin
        pick1  = req1 && (!req0 || !last1);
        accept = (state == IDLE) && (req0 || req1);
        sel_we = pick1 ? we1 : we0;
        sel_a  = pick1 ? a1  : a0;
        sel_wd = pick1 ? wd1 : wd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ACCESS;
            ACCESS:  state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Grants are gated by rst so they stay low while reset is held.
    always_comb begin
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        done0  = 1'b0;
        done1  = 1'b0;
        mem_we = 1'b0;
        case (state)
            IDLE: begin
                gnt0 = rst && req0 && !pick1;
                gnt1 = rst && pick1;
            end
            ACCESS: mem_we = we_q && in_range_q;
            RESP: begin
                done0 = !win_q;
                done1 = win_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last1      <= 1'b1;
            win_q      <= 1'b0;
            we_q       <= 1'b0;
            in_range_q <= 1'b0;
            mem_a      <= '0;
            mem_wd     <= '0;
            rdata      <= '0;
            err        <= 1'b0;
        end else begin
            if (accept) begin
                win_q      <= pick1;
                last1      <= pick1;
                we_q       <= sel_we;
                mem_a      <= sel_a;
                mem_wd     <= sel_wd;
                in_range_q <= sel_a < 32'(DEPTH);
            end
            if (state == ACCESS) begin
                rdata <= (!we_q && in_range_q) ? mem_rd : '0;
                err   <= !in_range_q;
            end
        end
    end

endmodule
